// File: rtl/demux_frame_8_pkg.sv
// ----------------------------------------------------------------------------
// demux_frame_8_pkg
// Shared definitions for the demux_frame_8 frame assembler:
//   CH        - number of output channels (frame width)
//   SW        - channel select width, CH == 2**SW
//   state_t   - assembler state encoding (FILL collects bits, HOLD offers frame)
//   FULL_MASK - mask value meaning every channel of the frame has been written
// ----------------------------------------------------------------------------
package demux_frame_8_pkg;

   localparam int CH = 8;
   localparam int SW = 3;

   typedef enum logic {
      ST_FILL = 1'b0,
      ST_HOLD = 1'b1
   } state_t;

   localparam logic [CH-1:0] FULL_MASK = {CH{1'b1}};

endpackage : demux_frame_8_pkg

// File: rtl/demux_frame_8_sel_decode.sv
// ----------------------------------------------------------------------------
// sel_decode
// SW-to-CH one-hot decoder gated by an enable strobe. With the enable tied to
// the accept strobe, each output bit is the write enable for one channel of
// the frame (and the set strobe for its mask bit).
// Ports:
//   i_en     - enable; all outputs are 0 when low
//   i_sel    - channel index
//   o_onehot - one-hot channel enable, bit i_sel set when i_en is high
// ----------------------------------------------------------------------------
module sel_decode
   import demux_frame_8_pkg::*;
(
   input  logic          i_en,
   input  logic [SW-1:0] i_sel,
   output logic [CH-1:0] o_onehot
);

   genvar gi;
   generate
      for (gi = 0; gi < CH; gi++) begin : g_dec
         assign o_onehot[gi] = i_en & (i_sel == SW'(gi));
      end
   endgenerate

endmodule : sel_decode

// File: rtl/demux_frame_8.sv
// ----------------------------------------------------------------------------
// demux_frame_8
// Sequential 1-to-8 frame assembler. Single data bits are steered into an
// 8-bit frame register either by an explicit select (addressed mode) or by
// an internal auto-incrementing pointer (auto mode). Once all eight channels
// have been written the frame is offered downstream on a valid/ready
// handshake; no new bits are accepted until it is taken.
// Ports:
//   clk       - rising-edge clock
//   rst       - asynchronous active-high reset
//   flush     - synchronous abort of the frame in progress (or the held frame)
//   auto_mode - 1: internal pointer selects the channel, 0: s selects it
//   in_valid  - A/s are valid this cycle
//   in_ready  - a bit can be accepted this cycle (state FILL)
//   A         - data bit
//   s         - channel select, used only in addressed mode
//   d         - assembled frame (registered)
//   out_valid - d holds a complete frame (state HOLD)
//   out_ready - downstream takes the frame
// ----------------------------------------------------------------------------
module demux_frame_8
   import demux_frame_8_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          auto_mode,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic          A,
   input  logic [SW-1:0] s,
   output logic [CH-1:0] d,
   output logic          out_valid,
   input  logic          out_ready
);

   state_t        r_state;
   logic [CH-1:0] r_d;
   logic [CH-1:0] r_mask;
   logic [SW-1:0] r_ptr;
   logic          r_mode_q;

   logic          w_accept;
   logic [SW-1:0] w_sel;
   logic [CH-1:0] w_wr;
   logic [CH-1:0] w_mask_next;

   // Handshake outputs come straight from the state register, so neither
   // in_valid nor out_ready has a combinational path to them.
   assign in_ready  = (r_state == ST_FILL);
   assign out_valid = (r_state == ST_HOLD);
   assign d         = r_d;

   // flush drops any accept attempted in the same cycle.
   assign w_accept  = in_valid & in_ready & ~flush;

   // Target channel: latched mode decides between pointer and external select.
   assign w_sel     = r_mode_q ? r_ptr : s;

   sel_decode u_sel_decode (
      .i_en     (w_accept),
      .i_sel    (w_sel),
      .o_onehot (w_wr)
   );

   assign w_mask_next = r_mask | w_wr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= ST_FILL;
         r_d      <= '0;
         r_mask   <= '0;
         r_ptr    <= '0;
         r_mode_q <= 1'b0;
      end else begin
         // The mode is only re-sampled between frames; once any channel is
         // written the frame keeps the mode it started with.
         if (r_mask == '0) begin
            r_mode_q <= auto_mode;
         end

         if (flush) begin
            // d is deliberately left alone: unwritten channels of the next
            // frame keep their previous value.
            r_state <= ST_FILL;
            r_mask  <= '0;
            r_ptr   <= '0;
         end else begin
            case (r_state)
               ST_FILL: begin
                  if (w_accept) begin
                     r_d    <= (r_d & ~w_wr) | ({CH{A}} & w_wr);
                     r_mask <= w_mask_next;
                     if (r_mode_q) begin
                        r_ptr <= r_ptr + SW'(1);
                     end
                     // A rewrite of an already-set channel leaves the mask
                     // unchanged, so only a genuinely new channel can finish.
                     if (w_mask_next == FULL_MASK) begin
                        r_state <= ST_HOLD;
                     end
                  end
               end
               ST_HOLD: begin
                  if (out_ready) begin
                     r_state <= ST_FILL;
                     r_mask  <= '0;
                     r_ptr   <= '0;
                  end
               end
               default: begin
                  r_state <= ST_FILL;
               end
            endcase
         end
      end
   end

endmodule : demux_frame_8

// File: tb/tb_demux_frame_8.sv
// ----------------------------------------------------------------------------
// tb_demux_frame_8
// Directed stimulus for demux_frame_8. Expected frames are queued when a
// frame's stimulus is issued; a monitor pops and compares whenever the DUT
// hands a frame over (out_valid & out_ready). Timing/boundary behaviour is
// checked directly by the stimulus process.
// ----------------------------------------------------------------------------
module tb_demux_frame_8;

   logic       clk;
   logic       rst;
   logic       flush;
   logic       auto_mode;
   logic       in_valid;
   logic       in_ready;
   logic       A;
   logic [2:0] s;
   logic [7:0] d;
   logic       out_valid;
   logic       out_ready;

   int checks = 0;
   int errors = 0;

   logic [7:0] exp_q[$];

   demux_frame_8 dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .auto_mode (auto_mode),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .s         (s),
      .d         (d),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end else begin
         $display("ok   %s: 0x%0h", name, act);
      end
   endtask

   // Inputs change 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic a, input logic [2:0] sel);
      in_valid = 1'b1;
      A        = a;
      s        = sel;
      tick();
      in_valid = 1'b0;
   endtask

   // Eight auto-mode accepts, bit i of v going to channel i.
   task automatic send_frame_auto(input logic [7:0] v, input string name);
      logic [7:0] bits;
      bits = v;
      for (int i = 0; i < 7; i++) begin
         send_bit(bits[i], 3'd0);
      end
      check({name, "_valid_before_8th"}, int'(out_valid), 0);
      send_bit(bits[7], 3'd0);
      check({name, "_valid_after_8th"}, int'(out_valid), 1);
      check({name, "_ready_after_8th"}, int'(in_ready), 0);
      check({name, "_d"}, int'(d), int'(v));
   endtask

   // Scoreboard monitor: a frame is handed over on the edge following a
   // cycle with out_valid & out_ready.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame: got d=0x%0h expected no frame", d);
         end else begin
            check("frame_out", int'(d), int'(exp_q.pop_front()));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst       = 1'b1;
      flush     = 1'b0;
      auto_mode = 1'b0;
      in_valid  = 1'b0;
      A         = 1'b0;
      s         = 3'd0;
      out_ready = 1'b0;

      // Reset state
      tick();
      tick();
      check("reset_d", int'(d), 0);
      check("reset_out_valid", int'(out_valid), 0);
      check("reset_in_ready", int'(in_ready), 1);
      rst = 1'b0;

      // Auto mode: A=1,0,1,1,0,0,1,0 -> d=8'b01001101, held until out_ready
      auto_mode = 1'b1;
      tick();
      exp_q.push_back(8'h4D);
      send_frame_auto(8'h4D, "auto");
      for (int i = 0; i < 2; i++) begin
         tick();
         check("auto_hold_in_ready", int'(in_ready), 0);
      end
      out_ready = 1'b1;
      tick();
      check("auto_release_valid", int'(out_valid), 0);
      check("auto_release_ready", int'(in_ready), 1);

      // Addressed mode: s=7..0 with A=s[0] -> 8'hAA
      auto_mode = 1'b0;
      tick();
      exp_q.push_back(8'hAA);
      for (int i = 7; i >= 0; i--) begin
         send_bit(i[0], 3'(i));
      end
      check("addr_valid", int'(out_valid), 1);
      check("addr_d", int'(d), 8'hAA);
      tick();

      // Addressed rewrite: ch3=1 then ch3=0, then remaining channels =1
      exp_q.push_back(8'hF7);
      send_bit(1'b1, 3'd3);
      send_bit(1'b0, 3'd3);
      send_bit(1'b1, 3'd0);
      send_bit(1'b1, 3'd1);
      send_bit(1'b1, 3'd2);
      send_bit(1'b1, 3'd4);
      send_bit(1'b1, 3'd5);
      send_bit(1'b1, 3'd6);
      check("rewrite_valid_after_8", int'(out_valid), 0);
      send_bit(1'b1, 3'd7);
      check("rewrite_valid_after_9", int'(out_valid), 1);
      check("rewrite_d", int'(d), 8'hF7);
      tick();

      // Backpressure: 5 cycles of HOLD with in_valid=1, then release
      auto_mode = 1'b1;
      out_ready = 1'b0;
      tick();
      exp_q.push_back(8'h3C);
      send_frame_auto(8'h3C, "bp");
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         A        = 1'b1;
         tick();
         check("bp_d_stable", int'(d), 8'h3C);
         check("bp_valid_held", int'(out_valid), 1);
      end
      // Release while in_valid is still high: that bit must not be taken.
      out_ready = 1'b1;
      in_valid  = 1'b1;
      A         = 1'b1;
      tick();
      in_valid = 1'b0;
      check("bp_release_valid", int'(out_valid), 0);
      check("bp_release_ready", int'(in_ready), 1);
      exp_q.push_back(8'hA5);
      send_frame_auto(8'hA5, "bp_next");
      tick();

      // Flush after 4 auto accepts, then a full fresh frame from ptr=0
      for (int i = 0; i < 4; i++) begin
         send_bit(1'b1, 3'd0);
      end
      flush    = 1'b1;
      in_valid = 1'b1;
      A        = 1'b0;
      tick();
      flush    = 1'b0;
      in_valid = 1'b0;
      check("flush_valid", int'(out_valid), 0);
      check("flush_ready", int'(in_ready), 1);
      check("flush_d_kept", int'(d), 8'hAF);
      exp_q.push_back(8'h5A);
      send_frame_auto(8'h5A, "post_flush");
      tick();

      // Flush coincident with the final accept: no frame, d[7] untouched
      for (int i = 0; i < 7; i++) begin
         send_bit(1'b1, 3'd0);
      end
      flush    = 1'b1;
      in_valid = 1'b1;
      A        = 1'b1;
      tick();
      flush    = 1'b0;
      in_valid = 1'b0;
      check("flush_final_valid", int'(out_valid), 0);
      check("flush_final_d", int'(d), 8'h7F);

      // Async reset while holding a frame
      out_ready = 1'b0;
      send_frame_auto(8'hC3, "pre_reset");
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_valid", int'(out_valid), 0);
      check("async_rst_d", int'(d), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      tick();
      check("post_rst_ready", int'(in_ready), 1);
      check("post_rst_valid", int'(out_valid), 0);

      check("queue_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_demux_frame_8
